// File: rtl/mac_cfg_sequencer_pkg.sv
// Shared encodings for the MAC config sequencer and the multiply blocks.
package mac_cfg_sequencer_pkg;

    // Precision configuration of an operand beat / the datapath.
    localparam logic [1:0] MAC_CFG_SINGLE  = 2'b00;
    localparam logic [1:0] MAC_CFG_DUAL    = 2'b01;
    localparam logic [1:0] MAC_CFG_QUAD    = 2'b10;
    localparam logic [1:0] MAC_CFG_ILLEGAL = 2'b11;

    // Sequencer states: accept beats, wait for the pipe to empty, apply new config.
    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StSwitch = 2'd2
    } mac_seq_state_e;

endpackage

// File: rtl/mac_valid_pipe.sv
// Shift register that carries {valid, last, grp_beats} alongside the MAC datapath.
module mac_valid_pipe #(
    parameter int unsigned Depth    = 2,
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                push_valid,
    input  logic                push_last,
    input  logic [CntWidth-1:0] push_beats,
    output logic                out_valid,
    output logic                out_last,
    output logic [CntWidth-1:0] out_beats,
    output logic                empty
);

    localparam int unsigned EntryW = CntWidth + 2;

    logic [Depth-1:0][EntryW-1:0] stage_q;
    logic [Depth-1:0][EntryW-1:0] stage_d;
    logic [EntryW-1:0]            entry_in;

    // Next-state shift; last/beats are zeroed on bubbles so idle stages read as all-zero.
    always_comb begin
        entry_in   = push_valid ? {1'b1, push_last, push_beats} : '0;
        stage_d    = stage_q;
        stage_d[0] = entry_in;
        for (int i = 1; i < int'(Depth); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Empty when no stage holds a valid beat.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < int'(Depth); i++) begin
            if (stage_q[i][EntryW-1]) begin
                empty = 1'b0;
            end
        end
    end

    assign {out_valid, out_last, out_beats} = stage_q[Depth-1];

endmodule

// File: rtl/mac_cfg_sequencer.sv
// Control sequencer in front of the MAC datapath: config switching with drain,
// group boundary tracking and latency-aligned valid/last regeneration.
module mac_cfg_sequencer
    import mac_cfg_sequencer_pkg::*;
#(
    parameter int unsigned MAC_CONF_WIDTH    = 2,
    parameter int unsigned MAC_PIPE_DEPTH    = 2,
    parameter int unsigned MAC_GRP_CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MAC_CONF_WIDTH-1:0]    in_cfg,
    input  logic                         in_last,
    output logic                         mac_en,
    output logic [MAC_CONF_WIDTH-1:0]    mac_cfg,
    output logic                         mac_first,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [MAC_GRP_CNT_WIDTH-1:0] grp_beats,
    output logic                         cfg_err,
    output logic                         busy
);

    localparam logic [MAC_CONF_WIDTH-1:0] CfgSingle = MAC_CONF_WIDTH'(MAC_CFG_SINGLE);
    localparam logic [MAC_CONF_WIDTH-1:0] CfgDual   = MAC_CONF_WIDTH'(MAC_CFG_DUAL);
    localparam logic [MAC_CONF_WIDTH-1:0] CfgQuad   = MAC_CONF_WIDTH'(MAC_CFG_QUAD);
    localparam logic [MAC_GRP_CNT_WIDTH-1:0] GrpCntMax = {MAC_GRP_CNT_WIDTH{1'b1}};

    mac_seq_state_e                state_q, state_d;
    logic [MAC_CONF_WIDTH-1:0]     mac_cfg_q, mac_cfg_d;
    logic [MAC_CONF_WIDTH-1:0]     pend_cfg_q, pend_cfg_d;
    logic [MAC_GRP_CNT_WIDTH-1:0]  grp_cnt_q, grp_cnt_d;
    logic                          first_pending_q, first_pending_d;
    logic                          cfg_err_q, cfg_err_d;
    logic                          busy_q, busy_d;

    logic                          cfg_legal;
    logic                          cfg_match;
    logic [MAC_GRP_CNT_WIDTH-1:0]  grp_cnt_inc;
    logic                          pipe_empty;
    logic                          push_valid;
    logic                          push_last;
    logic [MAC_GRP_CNT_WIDTH-1:0]  push_beats;

    // Beat classification and saturating group count including the current beat.
    always_comb begin
        cfg_legal   = (in_cfg == CfgSingle) || (in_cfg == CfgDual) || (in_cfg == CfgQuad);
        cfg_match   = (in_cfg == mac_cfg_q);
        grp_cnt_inc = (grp_cnt_q == GrpCntMax) ? grp_cnt_q
                                               : grp_cnt_q + MAC_GRP_CNT_WIDTH'(1);
    end

    // Next-state and handshake/datapath-control outputs.
    always_comb begin
        state_d         = state_q;
        mac_cfg_d       = mac_cfg_q;
        pend_cfg_d      = pend_cfg_q;
        grp_cnt_d       = grp_cnt_q;
        first_pending_d = first_pending_q;
        cfg_err_d       = 1'b0;
        in_ready        = 1'b0;
        mac_en          = 1'b0;
        mac_first       = 1'b0;
        push_valid      = 1'b0;
        push_last       = 1'b0;
        push_beats      = '0;

        unique case (state_q)
            StRun: begin
                if (in_valid && cfg_legal && !cfg_match) begin
                    // Hold the beat off; it is re-offered once the new config is applied.
                    pend_cfg_d = in_cfg;
                    state_d    = StDrain;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid && !cfg_legal) begin
                        // Illegal beat is swallowed without touching group state.
                        cfg_err_d = 1'b1;
                    end else if (in_valid) begin
                        mac_en     = 1'b1;
                        mac_first  = first_pending_q;
                        push_valid = 1'b1;
                        push_last  = in_last;
                        push_beats = grp_cnt_inc;
                        if (in_last) begin
                            grp_cnt_d       = '0;
                            first_pending_d = 1'b1;
                        end else begin
                            grp_cnt_d       = grp_cnt_inc;
                            first_pending_d = 1'b0;
                        end
                    end
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    state_d = StSwitch;
                end
            end
            StSwitch: begin
                // Any group still open under the old config is abandoned here.
                mac_cfg_d       = pend_cfg_q;
                first_pending_d = 1'b1;
                grp_cnt_d       = '0;
                state_d         = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        busy_d = !pipe_empty || (state_q != StRun);

        if (rst) begin
            in_ready   = 1'b0;
            mac_en     = 1'b0;
            mac_first  = 1'b0;
            push_valid = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRun;
            mac_cfg_q       <= CfgSingle;
            pend_cfg_q      <= CfgSingle;
            grp_cnt_q       <= '0;
            first_pending_q <= 1'b1;
            cfg_err_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mac_cfg_q       <= mac_cfg_d;
            pend_cfg_q      <= pend_cfg_d;
            grp_cnt_q       <= grp_cnt_d;
            first_pending_q <= first_pending_d;
            cfg_err_q       <= cfg_err_d;
            busy_q          <= busy_d;
        end
    end

    mac_valid_pipe #(
        .Depth    (MAC_PIPE_DEPTH),
        .CntWidth (MAC_GRP_CNT_WIDTH)
    ) u_valid_pipe (
        .clk        (clk),
        .clear      (rst),
        .push_valid (push_valid),
        .push_last  (push_last),
        .push_beats (push_beats),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_beats  (grp_beats),
        .empty      (pipe_empty)
    );

    assign mac_cfg = mac_cfg_q;
    assign cfg_err = cfg_err_q;
    assign busy    = busy_q;

endmodule
